// File: rtl/ring_pkg.sv
// Shared definitions for the one-hot ring counter and its monitor.
// Holds the monitor state encoding and the single definition of the rotation rule.
package ring_pkg;

    localparam int RING_W = 4;
    localparam int ROT_MAX_W = 32;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    // Token moves one position towards bit 0; bit 0 wraps to bit msb (ring width - 1).
    function automatic logic [ROT_MAX_W-1:0] rot_next(input logic [ROT_MAX_W-1:0] cur,
                                                      input logic [4:0]           msb);
        logic [ROT_MAX_W-1:0] nxt;
        nxt      = cur >> 1;
        nxt[msb] = cur[0];
        return nxt;
    endfunction

endpackage

// File: rtl/onehot_enc.sv
// Combinational one-hot to index encoder with a one-hot validity flag.
// Zero latency; index is forced to 0 whenever the input is not exactly one-hot.
module onehot_enc #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]         i_vec,
    output logic [$clog2(WIDTH)-1:0] o_idx,
    output logic                     o_onehot
);

    localparam int IW = $clog2(WIDTH);

    logic [IW-1:0] w_idx;
    logic          w_onehot;

    assign w_onehot = $onehot(i_vec);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_vec[i]) begin
                w_idx = w_idx | IW'(i);
            end
        end
    end

    assign o_idx    = w_onehot ? w_idx : '0;
    assign o_onehot = w_onehot;

endmodule

// File: rtl/ring_token_monitor.sv
// Checks a one-hot ring counter every clock, locks onto it and counts revolutions.
// All outputs registered with 1-cycle latency; any illegal step while locked is a sticky fault until clear.
module ring_token_monitor
    import ring_pkg::*;
#(
    parameter int WIDTH    = RING_W,
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     clear,
    output logic [$clog2(WIDTH)-1:0] phase,
    output logic                     locked,
    output logic                     err,
    output logic [CNT_W-1:0]         rev_count
);

    localparam int IW   = $clog2(WIDTH);
    localparam int MC_W = 4;

    state_t            r_state;
    state_t            w_nxt_state;
    logic [WIDTH-1:0]  r_prev;
    logic [MC_W-1:0]   r_match_cnt;
    logic [MC_W-1:0]   w_nxt_match_cnt;
    logic [CNT_W-1:0]  r_rev_count;
    logic [CNT_W-1:0]  w_nxt_rev_count;
    logic [IW-1:0]     r_phase;
    logic              r_locked;
    logic              r_err;

    logic [IW-1:0]     w_in_idx;
    logic              w_in_onehot;
    logic [IW-1:0]     w_prev_idx;
    logic              w_prev_onehot;
    logic [IW-1:0]     w_expect_idx;
    logic              w_step_ok;

    onehot_enc #(.WIDTH(WIDTH)) u_enc_in (
        .i_vec    (ring_in),
        .o_idx    (w_in_idx),
        .o_onehot (w_in_onehot)
    );

    onehot_enc #(.WIDTH(WIDTH)) u_enc_prev (
        .i_vec    (r_prev),
        .o_idx    (w_prev_idx),
        .o_onehot (w_prev_onehot)
    );

    // Rotation moves the hot bit one place down, wrapping 0 -> WIDTH-1.
    assign w_expect_idx = (w_prev_idx == '0) ? IW'(WIDTH - 1) : (w_prev_idx - 1'b1);
    assign w_step_ok    = w_in_onehot && w_prev_onehot && (w_in_idx == w_expect_idx);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= SEARCH;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_match_cnt = r_match_cnt;
        w_nxt_rev_count = r_rev_count;
        if (clear) begin
            w_nxt_state     = SEARCH;
            w_nxt_match_cnt = '0;
            w_nxt_rev_count = '0;
        end else begin
            case (r_state)
                SEARCH: begin
                    if (!w_step_ok) begin
                        w_nxt_match_cnt = '0;
                    end else if (r_match_cnt == MC_W'(LOCK_CNT - 1)) begin
                        w_nxt_state     = LOCKED;
                        w_nxt_match_cnt = '0;
                    end else begin
                        w_nxt_match_cnt = r_match_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (!w_step_ok) begin
                        w_nxt_state = FAULT;
                    end else if (ring_in[0] && !(&r_rev_count)) begin
                        w_nxt_rev_count = r_rev_count + 1'b1;
                    end
                end
                FAULT: begin
                    w_nxt_state = FAULT;
                end
                default: begin
                    w_nxt_state     = SEARCH;
                    w_nxt_match_cnt = '0;
                end
            endcase
        end
    end

    // prev and phase track the input in every state, including across clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev      <= '0;
            r_match_cnt <= '0;
            r_rev_count <= '0;
            r_phase     <= '0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_prev      <= ring_in;
            r_match_cnt <= w_nxt_match_cnt;
            r_rev_count <= w_nxt_rev_count;
            r_phase     <= w_in_idx;
            r_locked    <= (w_nxt_state == LOCKED);
            r_err       <= (w_nxt_state == FAULT);
        end
    end

    assign phase     = r_phase;
    assign locked    = r_locked;
    assign err       = r_err;
    assign rev_count = r_rev_count;

endmodule

// File: tb/tb_ring_token_monitor.sv
// Randomized scoreboard bench for ring_token_monitor (CNT_W=8 and CNT_W=2 instances side by side).
// Expected outputs come from a phase-index reference model; a monitor pops and compares each cycle.
module tb_ring_token_monitor;
    import ring_pkg::*;

    localparam int W  = 4;
    localparam int LC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic [3:0] ring_in;
    logic [1:0] phase_a, phase_b;
    logic       locked_a, locked_b, err_a, err_b;
    logic [7:0] rev_a;
    logic [1:0] rev_b;

    always #5 clk = ~clk;

    ring_token_monitor #(.WIDTH(W), .CNT_W(8), .LOCK_CNT(LC)) dut (
        .clk(clk), .reset(reset), .ring_in(ring_in), .clear(clear),
        .phase(phase_a), .locked(locked_a), .err(err_a), .rev_count(rev_a)
    );

    ring_token_monitor #(.WIDTH(W), .CNT_W(2), .LOCK_CNT(LC)) dut_sat (
        .clk(clk), .reset(reset), .ring_in(ring_in), .clear(clear),
        .phase(phase_b), .locked(locked_b), .err(err_b), .rev_count(rev_b)
    );

    typedef struct {
        int phase;
        bit locked;
        bit err;
        int rev8;
        int rev2;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: phases as integers, -1 meaning "not one-hot".
    int   m_prev;
    int   m_run;
    int   m_rev8;
    int   m_rev2;
    bit   m_locked;
    bit   m_err;
    logic [3:0] last_ring;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int idx_of(input logic [3:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < W; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [3:0] next_ring(input logic [3:0] v);
        logic [ROT_MAX_W-1:0] t;
        t = rot_next(ROT_MAX_W'(v), 5'(W - 1));
        return t[3:0];
    endfunction

    task automatic model_reset();
        m_prev = -1; m_run = 0; m_rev8 = 0; m_rev2 = 0;
        m_locked = 1'b0; m_err = 1'b0;
    endtask

    task automatic drive(input logic [3:0] r, input bit c);
        int   cur;
        bit   good;
        exp_t e;
        @(negedge clk);
        ring_in = r;
        clear   = c;
        last_ring = r;
        cur  = idx_of(r);
        good = (cur >= 0) && (m_prev >= 0) && (cur == (m_prev + W - 1) % W);
        if (c) begin
            m_locked = 1'b0; m_err = 1'b0; m_run = 0; m_rev8 = 0; m_rev2 = 0;
        end else if (!m_err) begin
            if (m_locked) begin
                if (!good) begin
                    m_locked = 1'b0;
                    m_err    = 1'b1;
                end else if (cur == 0) begin
                    if (m_rev8 < 255) m_rev8++;
                    if (m_rev2 < 3)   m_rev2++;
                end
            end else if (good) begin
                m_run++;
                if (m_run == LC) begin
                    m_locked = 1'b1;
                    m_run    = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        m_prev   = cur;
        e.phase  = (cur < 0) ? 0 : cur;
        e.locked = m_locked;
        e.err    = m_err;
        e.rev8   = m_rev8;
        e.rev2   = m_rev2;
        q.push_back(e);
    endtask

    task automatic run_steps(input int n);
        for (int i = 0; i < n; i++) drive(next_ring(last_ring), 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_phase"},  int'(phase_a) + int'(phase_b), 0);
        chk({tag, "_locked"}, int'(locked_a) + int'(locked_b), 0);
        chk({tag, "_err"},    int'(err_a) + int'(err_b), 0);
        chk({tag, "_rev"},    int'(rev_a) + int'(rev_b), 0);
    endtask

    // Reset is asserted between clock edges, after the pending expectation has been consumed.
    task automatic pulse_reset(input string tag);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_all_zero(tag);
        model_reset();
        last_ring = 4'b0000;
        @(posedge clk);
        #3;
        reset = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("phase",      int'(phase_a),  e.phase);
                chk("locked",     int'(locked_a), int'(e.locked));
                chk("err",        int'(err_a),    int'(e.err));
                chk("rev_count",  int'(rev_a),    e.rev8);
                chk("sat_phase",  int'(phase_b),  e.phase);
                chk("sat_locked", int'(locked_b), int'(e.locked));
                chk("sat_err",    int'(err_b),    int'(e.err));
                chk("sat_rev",    int'(rev_b),    e.rev2);
                chk("lock_err_excl", int'(locked_a & err_a), 0);
            end
        end
    end

    initial begin : stimulus
        int k;
        reset   = 1'b0;
        clear   = 1'b0;
        ring_in = 4'b0000;
        model_reset();
        last_ring = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        @(posedge clk);
        #3;
        reset = 1'b1;

        // First revolution: lock after the 3rd edge, one revolution after the 5th.
        drive(4'b0001, 1'b0);
        drive(4'b1000, 1'b0);
        drive(4'b0100, 1'b0);
        drive(4'b0010, 1'b0);
        drive(4'b0001, 1'b0);
        run_steps(2);

        // Held value while locked, then clear on a valid step and relock.
        drive(4'b0100, 1'b0);
        drive(4'b0100, 1'b0);
        drive(4'b0010, 1'b1);
        drive(4'b0001, 1'b0);
        drive(4'b1000, 1'b0);
        run_steps(3);

        // Multi-hot input while locked.
        drive(4'b0110, 1'b0);
        drive(4'b0001, 1'b0);
        drive(4'b1000, 1'b1);
        run_steps(2);

        // Saturation of the narrow counter over many revolutions.
        run_steps(5 * W + 1);

        // Async reset mid-revolution with two revolutions counted, then relock.
        drive(4'b0001, 1'b1);
        run_steps(9);
        pulse_reset("mid_rev_reset");
        drive(4'b0001, 1'b0);
        drive(4'b1000, 1'b0);
        drive(4'b0100, 1'b0);
        run_steps(2);

        // Randomized mix of good steps, glitches, holds, wrong direction and clears.
        for (int i = 0; i < 1500; i++) begin
            k = $urandom_range(0, 99);
            if (k < 82)      drive(next_ring(last_ring), 1'b0);
            else if (k < 87) drive(4'($urandom_range(0, 15)), 1'b0);
            else if (k < 90) drive(last_ring, 1'b0);
            else if (k < 93) drive(4'b0001 << $urandom_range(0, W - 1), 1'b0);
            else if (k < 97) drive(next_ring(last_ring), 1'b1);
            else             drive(4'($urandom_range(0, 15)), 1'b1);
        end

        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
